predictor_mvmult_kernels: RTL and testbench

//  Three independent fixed-point matrix-vector kernels of the predictor datapath, each with its own start/done handshake:
//  ROW: temp1 = A*x (2x2); ROW1: temp2 = B*u (2x1); COLUMN: lhs = C*temp3 (1x2).
//  The parent FSM starts ROW and ROW1 together, adds their results externally, then starts COLUMN and saturates its output.

---
 rtl/predictor_pkg.sv | 31 +++
 rtl/predictor_mvmult_engine.sv | 78 +++++++
 rtl/predictor_mvmult_kernels.sv | 93 +++++++++
 tb/tb_predictor_mvmult_kernels.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/predictor_pkg.sv
// Shared Q32.32 types, kernel coefficients and the fixed-point multiply used
// by the predictor matrix-vector kernels.
package predictor_pkg;

  localparam int FRAC_BITS = 32;

  typedef logic signed [63:0] q32_32_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IT0,
    S_IT1,
    S_DONE
  } eng_state_e;

  localparam q32_32_t A00 = 64'sh0000_0000_8000_0000;
  localparam q32_32_t A01 = 64'sh0000_0000_4000_0000;
  localparam q32_32_t A10 = 64'shFFFF_FFFF_C000_0000;
  localparam q32_32_t A11 = 64'sh0000_0000_C000_0000;
  localparam q32_32_t B0  = 64'sh0000_0000_2000_0000;
  localparam q32_32_t B1  = 64'sh0000_0001_0000_0000;
  localparam q32_32_t C0  = 64'sh0000_0001_0000_0000;
  localparam q32_32_t C1  = 64'sh0000_0000_8000_0000;

  // Full 128-bit signed product, arithmetic shift keeps floor semantics,
  // and the cast keeps bits [95:32] of the product.
  function automatic q32_32_t qmul(input q32_32_t a, input q32_32_t b);
    return q32_32_t'((128'(a) * 128'(b)) >>> FRAC_BITS);
  endfunction

endpackage

// File: rtl/predictor_mvmult_engine.sv
// Generic two-iteration matrix-vector engine: element 0 in IT0, element 1 in
// IT1, outputs published on entry to DONE. NUM_OUT=1 reduces both to one sum.
module predictor_mvmult_engine
  import predictor_pkg::*;
#(
  parameter q32_32_t K00     = '0,
  parameter q32_32_t K01     = '0,
  parameter q32_32_t K10     = '0,
  parameter q32_32_t K11     = '0,
  parameter int      NUM_OUT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [63:0]            a,
  input  logic [63:0]            b,
  output logic                   done,
  output logic                   idle,
  output logic                   ready,
  output logic [NUM_OUT*64-1:0]  res
);

  eng_state_e state, state_nx;

  q32_32_t a_q, b_q, acc0;
  q32_32_t e0, e1;
  logic [NUM_OUT*64-1:0] res_nx;

  assign e0 = qmul(K00, a_q) + qmul(K01, b_q);
  assign e1 = qmul(K10, a_q) + qmul(K11, b_q);

  if (NUM_OUT == 1) begin : g_reduce
    assign res_nx = acc0 + e1;
  end else begin : g_pair
    assign res_nx = {e1, acc0};
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_IT0;
      S_IT0:   state_nx = S_IT1;
      S_IT1:   state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc0  <= '0;
      res   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          a_q <= a;
          b_q <= b;
        end
        S_IT0:   acc0 <= e0;
        S_IT1:   res  <= res_nx;
        default: ;
      endcase
    end
  end

  assign done  = (state == S_DONE);
  assign ready = (state == S_DONE);
  assign idle  = (state == S_IDLE) && !start;

endmodule

// File: rtl/predictor_mvmult_kernels.sv
// ROW (A*x), ROW1 (B*u) and COLUMN (C*temp3) kernels of the predictor datapath,
// each an independent engine with its own start/done handshake.
module predictor_mvmult_kernels
  import predictor_pkg::*;
(
  input  logic        ap_clk,
  input  logic        ap_rst_n,

  input  logic        row_ap_start,
  output logic        row_ap_done,
  output logic        row_ap_idle,
  output logic        row_ap_ready,
  input  logic [63:0] row_x0,
  input  logic [95:0] row_x1_shl,
  output logic [63:0] row_t0_out,
  output logic        row_t0_out_ap_vld,
  output logic [63:0] row_t1_out,
  output logic        row_t1_out_ap_vld,

  input  logic        row1_ap_start,
  output logic        row1_ap_done,
  output logic        row1_ap_idle,
  output logic        row1_ap_ready,
  input  logic [63:0] row1_u,
  output logic [63:0] row1_t0_out,
  output logic        row1_t0_out_ap_vld,
  output logic [63:0] row1_t1_out,
  output logic        row1_t1_out_ap_vld,

  input  logic        col_ap_start,
  output logic        col_ap_done,
  output logic        col_ap_idle,
  output logic        col_ap_ready,
  input  logic [63:0] col_t0,
  input  logic [63:0] col_t1,
  output logic [63:0] col_lhs_out,
  output logic        col_lhs_out_ap_vld
);

  // The low word of the pre-shifted x[1] carries no information.
  logic unused_x1_frac;
  assign unused_x1_frac = ^row_x1_shl[31:0];

  predictor_mvmult_engine #(
    .K00(A00), .K01(A01), .K10(A10), .K11(A11), .NUM_OUT(2)
  ) u_row (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .start (row_ap_start),
    .a     (row_x0),
    .b     (row_x1_shl[95:32]),
    .done  (row_ap_done),
    .idle  (row_ap_idle),
    .ready (row_ap_ready),
    .res   ({row_t1_out, row_t0_out})
  );

  predictor_mvmult_engine #(
    .K00(B0), .K01('0), .K10(B1), .K11('0), .NUM_OUT(2)
  ) u_row1 (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .start (row1_ap_start),
    .a     (row1_u),
    .b     (64'd0),
    .done  (row1_ap_done),
    .idle  (row1_ap_idle),
    .ready (row1_ap_ready),
    .res   ({row1_t1_out, row1_t0_out})
  );

  // Diagonal coefficients give C0*t0 in IT0 and C1*t1 in IT1; NUM_OUT=1 sums them.
  predictor_mvmult_engine #(
    .K00(C0), .K01('0), .K10('0), .K11(C1), .NUM_OUT(1)
  ) u_col (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .start (col_ap_start),
    .a     (col_t0),
    .b     (col_t1),
    .done  (col_ap_done),
    .idle  (col_ap_idle),
    .ready (col_ap_ready),
    .res   (col_lhs_out)
  );

  assign row_t0_out_ap_vld  = row_ap_done;
  assign row_t1_out_ap_vld  = row_ap_done;
  assign row1_t0_out_ap_vld = row1_ap_done;
  assign row1_t1_out_ap_vld = row1_ap_done;
  assign col_lhs_out_ap_vld = col_ap_done;

endmodule

// File: tb/tb_predictor_mvmult_kernels.sv
// Directed self-checking bench for predictor_mvmult_kernels; expected values
// are hand-computed Q32.32 results.
module tb_predictor_mvmult_kernels;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        row_ap_start, row_ap_done, row_ap_idle, row_ap_ready;
  logic [63:0] row_x0;
  logic [95:0] row_x1_shl;
  logic [63:0] row_t0_out, row_t1_out;
  logic        row_t0_out_ap_vld, row_t1_out_ap_vld;
  logic        row1_ap_start, row1_ap_done, row1_ap_idle, row1_ap_ready;
  logic [63:0] row1_u, row1_t0_out, row1_t1_out;
  logic        row1_t0_out_ap_vld, row1_t1_out_ap_vld;
  logic        col_ap_start, col_ap_done, col_ap_idle, col_ap_ready;
  logic [63:0] col_t0, col_t1, col_lhs_out;
  logic        col_lhs_out_ap_vld;

  int n_pass  = 0;
  int n_total = 0;

  always #5 ap_clk = ~ap_clk;

  predictor_mvmult_kernels dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .row_ap_start(row_ap_start), .row_ap_done(row_ap_done),
    .row_ap_idle(row_ap_idle), .row_ap_ready(row_ap_ready),
    .row_x0(row_x0), .row_x1_shl(row_x1_shl),
    .row_t0_out(row_t0_out), .row_t0_out_ap_vld(row_t0_out_ap_vld),
    .row_t1_out(row_t1_out), .row_t1_out_ap_vld(row_t1_out_ap_vld),
    .row1_ap_start(row1_ap_start), .row1_ap_done(row1_ap_done),
    .row1_ap_idle(row1_ap_idle), .row1_ap_ready(row1_ap_ready),
    .row1_u(row1_u),
    .row1_t0_out(row1_t0_out), .row1_t0_out_ap_vld(row1_t0_out_ap_vld),
    .row1_t1_out(row1_t1_out), .row1_t1_out_ap_vld(row1_t1_out_ap_vld),
    .col_ap_start(col_ap_start), .col_ap_done(col_ap_done),
    .col_ap_idle(col_ap_idle), .col_ap_ready(col_ap_ready),
    .col_t0(col_t0), .col_t1(col_t1),
    .col_lhs_out(col_lhs_out), .col_lhs_out_ap_vld(col_lhs_out_ap_vld)
  );

  function automatic logic sel_done(input int k);
    case (k)
      0:       return row_ap_done;
      1:       return row1_ap_done;
      default: return col_ap_done;
    endcase
  endfunction

  // Negedges until kernel k reports done; -1 if it never does within the bound.
  task automatic wait_done(input int k, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge ap_clk);
      if (sel_done(k)) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge ap_clk);
    n_total++;
    if ({row_t0_out, row_t1_out, row1_t0_out, row1_t1_out, col_lhs_out} !== 320'd0)
      $display("FAIL reset_data: got %h exp 0",
               {row_t0_out, row_t1_out, row1_t0_out, row1_t1_out, col_lhs_out});
    else n_pass++;
    n_total++;
    if ({row_ap_idle, row1_ap_idle, col_ap_idle} !== 3'b111)
      $display("FAIL reset_idle: got %b exp 111", {row_ap_idle, row1_ap_idle, col_ap_idle});
    else n_pass++;
    n_total++;
    if ({row_ap_done, row1_ap_done, col_ap_done, row_ap_ready, row1_ap_ready, col_ap_ready,
         row_t0_out_ap_vld, row1_t1_out_ap_vld, col_lhs_out_ap_vld} !== 9'd0)
      $display("FAIL reset_ctrl: got %b exp 0",
               {row_ap_done, row1_ap_done, col_ap_done, row_ap_ready, row1_ap_ready,
                col_ap_ready, row_t0_out_ap_vld, row1_t1_out_ap_vld, col_lhs_out_ap_vld});
    else n_pass++;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_row;
    int cyc;
    row_x0       = 64'h0000_0001_0000_0000;
    row_x1_shl   = {64'h0000_0002_0000_0000, 32'hDEAD_BEEF};
    row_ap_start = 1'b1;
    wait_done(0, cyc);
    row_ap_start = 1'b0;
    n_total++;
    if (cyc !== 3) $display("FAIL row_latency: got %0d exp 3", cyc); else n_pass++;
    n_total++;
    if (row_t0_out !== 64'h0000_0001_0000_0000)
      $display("FAIL row_t0: got %h exp 0000000100000000", row_t0_out);
    else n_pass++;
    n_total++;
    if (row_t1_out !== 64'h0000_0001_4000_0000)
      $display("FAIL row_t1: got %h exp 0000000140000000", row_t1_out);
    else n_pass++;
    n_total++;
    if ({row_ap_ready, row_t0_out_ap_vld, row_t1_out_ap_vld} !== 3'b111)
      $display("FAIL row_pulses: got %b exp 111",
               {row_ap_ready, row_t0_out_ap_vld, row_t1_out_ap_vld});
    else n_pass++;
    @(negedge ap_clk);
    n_total++;
    if ({row_ap_done, row_ap_ready, row_t0_out_ap_vld, row_t1_out_ap_vld, row_ap_idle} !== 5'b00001)
      $display("FAIL row_after_done: got %b exp 00001",
               {row_ap_done, row_ap_ready, row_t0_out_ap_vld, row_t1_out_ap_vld, row_ap_idle});
    else n_pass++;
    n_total++;
    if (row_t1_out !== 64'h0000_0001_4000_0000)
      $display("FAIL row_hold: got %h exp 0000000140000000", row_t1_out);
    else n_pass++;
  endtask

  task automatic test_row_row1;
    int c_row = -1;
    int c_row1 = -1;
    row_x0        = 64'h0000_0002_0000_0000;
    row_x1_shl    = 96'd0;
    row1_u        = 64'h0000_0002_0000_0000;
    row_ap_start  = 1'b1;
    row1_ap_start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge ap_clk);
      if (row_ap_done && c_row < 0) begin
        c_row = i;
        row_ap_start = 1'b0;
      end
      if (row1_ap_done && c_row1 < 0) begin
        c_row1 = i;
        row1_ap_start = 1'b0;
      end
      if (c_row > 0 && c_row1 > 0) break;
    end
    row_ap_start  = 1'b0;
    row1_ap_start = 1'b0;
    n_total++;
    if (c_row !== 3 || c_row1 !== 3)
      $display("FAIL sim_done_cycles: got row=%0d row1=%0d exp 3/3", c_row, c_row1);
    else n_pass++;
    n_total++;
    if ({row1_t0_out, row1_t1_out} !== {64'h0000_0000_4000_0000, 64'h0000_0002_0000_0000})
      $display("FAIL row1_out: got %h %h exp 0000000040000000 0000000200000000",
               row1_t0_out, row1_t1_out);
    else n_pass++;
    n_total++;
    if ({row_t0_out, row_t1_out} !== {64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0000})
      $display("FAIL row_neg: got %h %h exp 0000000100000000 ffffffff80000000",
               row_t0_out, row_t1_out);
    else n_pass++;
  endtask

  task automatic test_col(input logic [63:0] t0, input logic [63:0] t1,
                          input logic [63:0] exp_lhs);
    int cyc;
    col_t0       = t0;
    col_t1       = t1;
    col_ap_start = 1'b1;
    wait_done(2, cyc);
    col_ap_start = 1'b0;
    n_total++;
    if (cyc !== 3 || col_lhs_out_ap_vld !== 1'b1)
      $display("FAIL col_done: got cyc=%0d vld=%b exp 3/1", cyc, col_lhs_out_ap_vld);
    else n_pass++;
    n_total++;
    if (col_lhs_out !== exp_lhs)
      $display("FAIL col_lhs: got %h exp %h", col_lhs_out, exp_lhs);
    else n_pass++;
    @(negedge ap_clk);
    n_total++;
    if (col_lhs_out_ap_vld !== 1'b0 || col_lhs_out !== exp_lhs)
      $display("FAIL col_vld_pulse: got vld=%b lhs=%h exp 0/%h",
               col_lhs_out_ap_vld, col_lhs_out, exp_lhs);
    else n_pass++;
  endtask

  task automatic test_truncation;
    int cyc;
    row_x0       = 64'h0000_0000_0000_0001;
    row_x1_shl   = 96'd0;
    row_ap_start = 1'b1;
    wait_done(0, cyc);
    row_ap_start = 1'b0;
    n_total++;
    if ({row_t0_out, row_t1_out} !== {64'd0, 64'hFFFF_FFFF_FFFF_FFFF})
      $display("FAIL trunc_pos: got %h %h exp 0 ffffffffffffffff", row_t0_out, row_t1_out);
    else n_pass++;
    @(negedge ap_clk);
    row_x0       = 64'hFFFF_FFFF_FFFF_FFFF;
    row_ap_start = 1'b1;
    wait_done(0, cyc);
    row_ap_start = 1'b0;
    n_total++;
    if ({row_t0_out, row_t1_out} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'd0})
      $display("FAIL trunc_neg: got %h %h exp ffffffffffffffff 0", row_t0_out, row_t1_out);
    else n_pass++;
    @(negedge ap_clk);
  endtask

  task automatic test_busy;
    int cyc;
    int extra = 0;
    row_x0       = 64'h0000_0001_0000_0000;
    row_x1_shl   = {64'h0000_0002_0000_0000, 32'd0};
    row_ap_start = 1'b1;
    @(negedge ap_clk);
    row_ap_start = 1'b0;
    row_x0       = 64'h0000_0010_0000_0000;
    row_x1_shl   = {64'h0000_0020_0000_0000, 32'd0};
    @(negedge ap_clk);
    row_ap_start = 1'b1;
    @(negedge ap_clk);
    n_total++;
    if (row_ap_done !== 1'b1) $display("FAIL busy_done: got %b exp 1", row_ap_done); else n_pass++;
    row_ap_start = 1'b0;
    n_total++;
    if ({row_t0_out, row_t1_out} !== {64'h0000_0001_0000_0000, 64'h0000_0001_4000_0000})
      $display("FAIL busy_result: got %h %h exp 0000000100000000 0000000140000000",
               row_t0_out, row_t1_out);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      if (row_ap_done) extra++;
    end
    n_total++;
    if (extra !== 0 || row_ap_idle !== 1'b1)
      $display("FAIL busy_ignored: got extra=%0d idle=%b exp 0/1", extra, row_ap_idle);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    row_x0       = 64'h0000_0004_0000_0000;
    row_x1_shl   = 96'd0;
    row_ap_start = 1'b1;
    wait_done(0, cyc);
    n_total++;
    if ({row_t0_out, row_t1_out} !== {64'h0000_0002_0000_0000, 64'hFFFF_FFFF_0000_0000})
      $display("FAIL b2b_first: got %h %h exp 0000000200000000 ffffffff00000000",
               row_t0_out, row_t1_out);
    else n_pass++;
    row_x0     = 64'd0;
    row_x1_shl = {64'h0000_0004_0000_0000, 32'd0};
    @(negedge ap_clk);
    n_total++;
    if ({row_ap_done, row_ap_idle} !== 2'b00)
      $display("FAIL b2b_cycle4: got done/idle=%b exp 00", {row_ap_done, row_ap_idle});
    else n_pass++;
    @(negedge ap_clk);
    row_ap_start = 1'b0;
    row_x1_shl   = {64'h0000_0077_0000_0000, 32'd0};
    wait_done(0, cyc);
    n_total++;
    if (cyc !== 2) $display("FAIL b2b_second_latency: got %0d exp 2", cyc); else n_pass++;
    n_total++;
    if ({row_t0_out, row_t1_out} !== {64'h0000_0001_0000_0000, 64'h0000_0003_0000_0000})
      $display("FAIL b2b_second: got %h %h exp 0000000100000000 0000000300000000",
               row_t0_out, row_t1_out);
    else n_pass++;
    @(negedge ap_clk);
  endtask

  task automatic test_reset_mid_run;
    int dones = 0;
    row_x0        = 64'h0000_0001_0000_0000;
    row1_u        = 64'h0000_0003_0000_0000;
    col_t0        = 64'h0000_0005_0000_0000;
    row_ap_start  = 1'b1;
    row1_ap_start = 1'b1;
    col_ap_start  = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst_n      = 1'b0;
    row_ap_start  = 1'b0;
    row1_ap_start = 1'b0;
    col_ap_start  = 1'b0;
    #1;
    n_total++;
    if ({row_t0_out, row_t1_out, row1_t0_out, row1_t1_out, col_lhs_out} !== 320'd0)
      $display("FAIL midrst_data: got %h exp 0",
               {row_t0_out, row_t1_out, row1_t0_out, row1_t1_out, col_lhs_out});
    else n_pass++;
    n_total++;
    if ({row_ap_idle, row1_ap_idle, col_ap_idle, row_ap_done, row1_ap_done, col_ap_done} !== 6'b111000)
      $display("FAIL midrst_ctrl: got %b exp 111000",
               {row_ap_idle, row1_ap_idle, col_ap_idle, row_ap_done, row1_ap_done, col_ap_done});
    else n_pass++;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      if (row_ap_done || row1_ap_done || col_ap_done) dones++;
    end
    n_total++;
    if (dones !== 0) $display("FAIL midrst_no_done: got %0d exp 0", dones); else n_pass++;
  endtask

  initial begin
    ap_rst_n      = 1'b0;
    row_ap_start  = 1'b0;
    row1_ap_start = 1'b0;
    col_ap_start  = 1'b0;
    row_x0        = '0;
    row_x1_shl    = '0;
    row1_u        = '0;
    col_t0        = '0;
    col_t1        = '0;
    test_reset();
    @(negedge ap_clk);
    test_row();
    test_row_row1();
    @(negedge ap_clk);
    test_col(64'h0000_0003_0000_0000, 64'hFFFF_FFF9_0000_0000, 64'hFFFF_FFFF_8000_0000);
    test_truncation();
    test_busy();
    test_back_to_back();
    test_col(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hBFFF_FFFF_FFFF_FFFE);
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
